blinkt_led_monitor: RTL and testbench

- Serial receiver for the APA102/Blinkt LED stream: deserializes LED clock/data, frames start frame and LED frames, and captures a consistent snapshot of all LED words.
- Exposes the snapshot, a status word and a control word to the host as a Wishbone slave.
- Used for loopback checking of the LED bar transmitter on hardware and as a bus-readable monitor.

---
 rtl/blinkt_led_monitor_if.sv | 27 ++
 rtl/blinkt_led_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_blinkt_led_monitor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/blinkt_led_monitor_if.sv
// Wishbone classic slave bundle used by the Blinkt LED stream monitor.
interface blinkt_led_monitor_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_we_i;
    logic [SELECT_WIDTH-1:0] wb_sel_i;
    logic                    wb_stb_i;
    logic                    wb_ack_o;
    logic                    wb_err_o;
    logic                    wb_rty_o;
    logic                    wb_cyc_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/blinkt_led_monitor.sv
// APA102/Blinkt serial stream receiver: frames LED words, commits a consistent
// snapshot per update and exposes snapshot/status/control over Wishbone.
module blinkt_led_monitor #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    blinkt_led_monitor_if.slave   bus,
    input  logic                  i_led_clk,
    input  logic                  i_led_data,
    output logic                  o_frame_irq,
    output logic                  o_err
);

    localparam int unsigned WordW = 32;
    localparam int unsigned IdxW  = 4;
    localparam int unsigned CntW  = 16;
    localparam int unsigned ZeroW = 6;
    localparam int unsigned BitW  = 5;
    localparam int unsigned MaxLeds = 8;
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ZeroW-1:0] ZeroSat = ZeroW'(32);
    localparam logic [BitW-1:0]  LastBit = BitW'(31);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_LEDS - 1);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    logic               clk_meta, clk_sync, clk_prev;
    logic               dat_meta, dat_sync;
    logic [WordW-1:0]   shift;
    logic [WordW-1:0]   stage    [MaxLeds];
    logic [WordW-1:0]   snapshot [MaxLeds];
    logic [IdxW-1:0]    idx;
    logic [ZeroW-1:0]   zero_cnt;
    logic [BitW-1:0]    bit_cnt;
    logic [TmoW-1:0]    tmo_cnt;
    logic [CntW-1:0]    frame_cnt;
    logic               frame_err;
    logic               timeout_flag;

    logic               led_edge_c;
    logic [WordW-1:0]   word_c;
    logic               word_done_c;
    logic               word_ok_c;
    logic               frame_err_evt_c;
    logic               timeout_evt_c;
    logic               wb_hit_c;
    logic               ctl_wr_c;
    logic               clr_c;
    logic               abort_c;
    logic               frame_err_d;
    logic               timeout_d;
    logic [WordW-1:0]   status_c;
    logic [WordW-1:0]   rd_data_c;

    logic                    unused_ok;
    logic [SELECT_WIDTH-1:0] unused_sel;
    assign unused_sel = bus.wb_sel_i;
    assign unused_ok  = ^{bus.wb_adr_i[ADDR_WIDTH-1:4], bus.wb_dat_i[DATA_WIDTH-1:2]};

    // Bit acceptance, word checks, bus decode and next sticky-flag values
    always_comb begin
        led_edge_c      = clk_sync & ~clk_prev;
        word_c          = {shift[WordW-2:0], dat_sync};
        word_done_c     = (state == DATA) && led_edge_c && (bit_cnt == LastBit);
        word_ok_c       = (word_c[31:29] == 3'b111);
        frame_err_evt_c = word_done_c && !word_ok_c;
        timeout_evt_c   = (state == DATA) && !led_edge_c && (tmo_cnt == TmoLast);
        wb_hit_c        = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
        ctl_wr_c        = wb_hit_c & bus.wb_we_i & (bus.wb_adr_i[3:0] == 4'd9);
        clr_c           = ctl_wr_c & bus.wb_dat_i[0];
        abort_c         = ctl_wr_c & bus.wb_dat_i[1];
        // An error event in the same cycle as a clear leaves the flag set
        frame_err_d     = (frame_err & ~clr_c) | frame_err_evt_c;
        timeout_d       = (timeout_flag & ~clr_c) | timeout_evt_c;
        status_c        = {frame_cnt, 4'b0, idx, 2'b0, timeout_flag, frame_err, 2'b0, state};
        rd_data_c       = '0;
        if (32'(bus.wb_adr_i[3:0]) < NUM_LEDS) begin
            rd_data_c = snapshot[bus.wb_adr_i[2:0]];
        end else if (bus.wb_adr_i[3:0] == 4'd8) begin
            rd_data_c = status_c;
        end
    end

    // Synchronizers, framing FSM, snapshot commit and control
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            clk_meta     <= 1'b0;
            clk_sync     <= 1'b0;
            clk_prev     <= 1'b0;
            dat_meta     <= 1'b0;
            dat_sync     <= 1'b0;
            state        <= HUNT;
            shift        <= '0;
            stage        <= '{default: '0};
            snapshot     <= '{default: '0};
            idx          <= '0;
            zero_cnt     <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            frame_cnt    <= '0;
            frame_err    <= 1'b0;
            timeout_flag <= 1'b0;
            o_frame_irq  <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            clk_meta     <= i_led_clk;
            clk_sync     <= clk_meta;
            clk_prev     <= clk_sync;
            dat_meta     <= i_led_data;
            dat_sync     <= dat_meta;
            o_frame_irq  <= 1'b0;
            frame_err    <= frame_err_d;
            timeout_flag <= timeout_d;
            o_err        <= frame_err_d | timeout_d;

            case (state)
                HUNT: begin
                    tmo_cnt <= '0;
                    if (led_edge_c) begin
                        if (!dat_sync) begin
                            if (zero_cnt != ZeroSat) zero_cnt <= zero_cnt + ZeroW'(1);
                        end else if (zero_cnt == ZeroSat) begin
                            // First 1 after the start frame is bit 31 of LED word 0
                            state   <= DATA;
                            shift   <= WordW'(1);
                            bit_cnt <= BitW'(1);
                            idx     <= '0;
                        end else begin
                            zero_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (led_edge_c) begin
                        tmo_cnt <= '0;
                        shift   <= word_c;
                        if (bit_cnt == LastBit) begin
                            bit_cnt <= '0;
                            if (word_ok_c) begin
                                stage[idx[2:0]] <= word_c;
                                idx             <= idx + IdxW'(1);
                                if (idx == LastIdx) state <= COMMIT;
                            end else begin
                                state    <= HUNT;
                                zero_cnt <= '0;
                                idx      <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BitW'(1);
                        end
                    end else if (timeout_evt_c) begin
                        state    <= HUNT;
                        zero_cnt <= '0;
                        idx      <= '0;
                        bit_cnt  <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
                end
                COMMIT: begin
                    snapshot    <= stage;
                    frame_cnt   <= frame_cnt + CntW'(1);
                    o_frame_irq <= 1'b1;
                    state       <= HUNT;
                    zero_cnt    <= '0;
                    idx         <= '0;
                end
                default: begin
                    state    <= HUNT;
                    zero_cnt <= '0;
                    idx      <= '0;
                end
            endcase

            if (abort_c) begin
                state    <= HUNT;
                zero_cnt <= '0;
                idx      <= '0;
                bit_cnt  <= '0;
                tmo_cnt  <= '0;
            end
            if (clr_c) frame_cnt <= '0;
        end
    end

    // Single-cycle Wishbone acknowledge with registered read data
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
        end else begin
            bus.wb_ack_o <= wb_hit_c;
            if (wb_hit_c) bus.wb_dat_o <= DATA_WIDTH'(rd_data_c);
        end
    end

    assign bus.wb_err_o = 1'b0;
    assign bus.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_blinkt_led_monitor.sv
// Randomized bench for blinkt_led_monitor against a frame-level reference model.
module tb_blinkt_led_monitor;

    localparam int unsigned NUM_LEDS       = 8;
    localparam int unsigned TIMEOUT_CYCLES = 4096;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic led_clk = 1'b0;
    logic led_data = 1'b0;
    logic irq, err;

    always #5 i_clk = ~i_clk;

    blinkt_led_monitor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus ();

    blinkt_led_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
        .NUM_LEDS(NUM_LEDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .bus         (bus),
        .i_led_clk   (led_clk),
        .i_led_data  (led_data),
        .o_frame_irq (irq),
        .o_err       (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int irq_seen = 0;

    // Reference model: what the host should see after each whole frame
    logic [31:0] exp_snap [8];
    logic [31:0] frame_w  [8];
    int          exp_cnt;
    bit          exp_ferr, exp_tmo;
    int          exp_irq = 0;

    always @(negedge i_clk) if (irq) irq_seen++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        logic ackd;
        @(negedge i_clk);
        bus.wb_adr_i = adr; bus.wb_dat_i = wdat; bus.wb_we_i = we;
        bus.wb_sel_i = 4'hF; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        ackd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (bus.wb_ack_o) begin ackd = 1'b1; break; end
        end
        rdat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        check_eq("wb_ack", 32'(ackd), 32'd1);
        @(negedge i_clk);
        check_eq("wb_ack_drop", 32'(bus.wb_ack_o), 32'd0);
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, adr, 32'd0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        wb_xfer(1'b1, adr, dat, r);
    endtask

    function automatic logic [31:0] exp_status(input int st, input int ix);
        return (32'(exp_cnt) << 16) | (32'(ix) << 8) | (32'(exp_tmo) << 5)
             | (32'(exp_ferr) << 4) | 32'(st);
    endfunction

    task automatic send_bit(input logic b, input int period);
        led_data = b;
        repeat (period / 2) @(negedge i_clk);
        led_clk = 1'b1;
        repeat (period - period / 2) @(negedge i_clk);
        led_clk = 1'b0;
    endtask

    // Sends leading zeros, then the first nbits of the LED words
    task automatic send_prefix(input int nzeros, input int nbits, input int period);
        logic [31:0] w;
        @(negedge i_clk);
        for (int i = 0; i < nzeros; i++) send_bit(1'b0, period);
        for (int b = 0; b < nbits; b++) begin
            w = frame_w[b / 32];
            send_bit(w[31 - (b % 32)], period);
        end
    endtask

    task automatic send_frame(input int nzeros, input int period);
        bit ok;
        send_prefix(nzeros, 32 * NUM_LEDS, period);
        for (int i = 0; i < 32; i++) send_bit(1'b1, period);
        ok = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) if ((frame_w[i] >> 29) != 32'd7) ok = 1'b0;
        if (ok) begin
            for (int i = 0; i < NUM_LEDS; i++) exp_snap[i] = frame_w[i];
            exp_cnt = (exp_cnt + 1) & 32'hFFFF;
            exp_irq++;
        end else begin
            exp_ferr = 1'b1;
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic make_frame(input int bad_idx);
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i == bad_idx)
                frame_w[i] = (32'($urandom_range(0, 6)) << 29) | ($urandom & 32'h1FFF_FFFF);
            else
                frame_w[i] = 32'hE000_0000 | ($urandom & 32'h1FFF_FFFF);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NUM_LEDS; i++)
            read_check($sformatf("%s_snap%0d", tag, i), 32'(i), exp_snap[i]);
        read_check({tag, "_status"}, 32'd8, exp_status(0, 0));
        check_eq({tag, "_irq_count"}, 32'(irq_seen), 32'(exp_irq));
        check_eq({tag, "_o_err"}, 32'(err), 32'(exp_ferr | exp_tmo));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_snap[i] = 32'd0;
        exp_cnt = 0; exp_ferr = 1'b0; exp_tmo = 1'b0;
    endtask

    initial begin
        logic [31:0] wd;
        int period, bad;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = '0; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        model_reset();

        repeat (3) @(negedge i_clk);
        check_eq("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        i_rst = 1'b1;
        read_check("rst_snap0", 32'd0, 32'd0);
        read_check("rst_status", 32'd8, 32'd0);
        check_eq("rst_o_err", 32'(err), 32'd0);

        for (int i = 0; i < NUM_LEDS; i++) frame_w[i] = 32'hE000_0000 | (32'(i) * 32'h0001_0203);
        send_frame(32, 8);
        check_all("basic");

        send_frame(40, 37);
        check_all("slow");

        make_frame(-1);
        frame_w[5] = 32'h6000_00FF;
        send_frame(32, 8);
        check_all("bad5");

        // Stall mid-frame: 32 zeros plus 68 data bits leaves two words staged
        make_frame(-1);
        send_prefix(32, 68, 8);
        read_check("stall_status", 32'd8, exp_status(1, 2));
        repeat (TIMEOUT_CYCLES + 10) @(negedge i_clk);
        exp_tmo = 1'b1;
        check_all("timeout");
        make_frame(-1);
        send_frame(32, 8);
        check_all("after_tmo");

        wb_write(32'd9, 32'd1);
        exp_cnt = 0; exp_ferr = 1'b0; exp_tmo = 1'b0;
        check_all("clear");
        read_check("adr_c", 32'hC, 32'd0);
        read_check("adr_f", 32'hF, 32'd0);
        wd = $urandom;
        wb_write(32'd0, wd);
        read_check("ro_snap0", 32'd0, exp_snap[0]);

        make_frame(-1);
        send_prefix(32, 40, 8);
        read_check("pre_abort_status", 32'd8, exp_status(1, 1));
        wb_write(32'd9, 32'd2);
        check_all("abort");

        for (int f = 0; f < 5; f++) begin
            period = $urandom_range(4, 14);
            bad = ($urandom_range(0, 9) < 3) ? $urandom_range(1, NUM_LEDS - 1) : -1;
            make_frame(bad);
            send_frame($urandom_range(32, 40), period);
            check_all($sformatf("rand%0d", f));
        end

        make_frame(-1);
        send_prefix(32, 50, 8);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        check_eq("midrst_err", 32'(err), 32'd0);
        i_rst = 1'b1;
        model_reset();
        check_all("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
